pattern_timing_ctrl: RTL and testbench

//  Line/frame timing sequencer for the pattern generator control block.
//  - Generates the f_sync, sync, endLine and endFrame strobes that control block consumes.
//  - Latches the work mode and deltaX once per frame, so a mode change never tears a frame.
//  - Supports single-frame and continuous operation, plus a stop request that is honoured at the next line end.

---
 rtl/pattern_timing_ctrl.sv | 159 +++++++++++++++
 tb/tb_pattern_timing_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pattern_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pattern_timing_ctrl
// Function : Line/frame timing sequencer (sync/endLine/endFrame strobes) for
//            the pattern generator, with per-frame latching of mode and deltaX.
// Revision : 1.0  initial release
// ============================================================================
module pattern_timing_ctrl #(
    parameter int NORM_LEN = 4096,
    parameter int TEST_LEN = 1290,
    parameter int LINES    = 1024,
    parameter int H_BLANK  = 4,
    localparam int LW      = (LINES > 1) ? $clog2(LINES) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic          cont,
    input  logic [2:0]    mode_in,
    input  logic [1:0]    x_in,
    output logic [2:0]    mode_out,
    output logic [1:0]    x_out,
    output logic          f_sync,
    output logic          sync,
    output logic          endLine,
    output logic          endFrame,
    output logic          busy,
    output logic          cfg_err,
    output logic [11:0]   pix_cnt,
    output logic [LW-1:0] line_cnt
);

    localparam int BW = $clog2(H_BLANK + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LSYNC  = 2'd1,
        S_ACTIVE = 2'd2,
        S_BLANK  = 2'd3
    } state_t;

    state_t        r_state;
    logic [2:0]    r_mode;
    logic [1:0]    r_x;
    logic [11:0]   r_pix;
    logic [LW-1:0] r_line;
    logic [BW-1:0] r_blk;
    logic          r_stop_pend;
    logic          r_new_frame;
    logic          r_err;

    logic [11:0]   w_last;
    logic          w_eol;
    logic          w_stop;
    logic          w_eof;
    logic          w_restart;

    assign w_last    = (r_mode == 3'd1) ? 12'(NORM_LEN - 1) : 12'(TEST_LEN - 1);
    assign w_eol     = (r_state == S_ACTIVE) && (r_pix == w_last);
    assign w_stop    = stop | r_stop_pend;
    assign w_eof     = w_eol && ((r_line == LW'(LINES - 1)) || w_stop);
    assign w_restart = w_eof && cont && !w_stop && (mode_in != 3'd0);

    // Internal sequencer runs one cycle ahead; every port is a register
    // decoded from the sequencer state of the previous cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= 3'd0;
            r_x         <= 2'd0;
            r_pix       <= 12'd0;
            r_line      <= '0;
            r_blk       <= '0;
            r_stop_pend <= 1'b0;
            r_new_frame <= 1'b0;
            r_err       <= 1'b0;
            mode_out    <= 3'd0;
            x_out       <= 2'd0;
            f_sync      <= 1'b0;
            sync        <= 1'b0;
            endLine     <= 1'b0;
            endFrame    <= 1'b0;
            busy        <= 1'b0;
            cfg_err     <= 1'b0;
            pix_cnt     <= 12'd0;
            line_cnt    <= '0;
        end else begin
            sync     <= (r_state == S_LSYNC);
            f_sync   <= (r_state == S_LSYNC) && (r_line == '0);
            endLine  <= w_eol;
            endFrame <= w_eof;
            busy     <= (r_state != S_IDLE);
            cfg_err  <= r_err;
            pix_cnt  <= r_pix;
            line_cnt <= r_line;
            mode_out <= r_mode;
            x_out    <= r_x;
            r_err    <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_stop_pend <= 1'b0;
                    r_new_frame <= 1'b0;
                    if (start) begin
                        if (mode_in != 3'd0) begin
                            r_mode  <= mode_in;
                            r_x     <= x_in;
                            r_line  <= '0;
                            r_pix   <= 12'd0;
                            r_state <= S_LSYNC;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_LSYNC: begin
                    if (stop) r_stop_pend <= 1'b1;
                    r_state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (stop) r_stop_pend <= 1'b1;
                    if (!w_eol) r_pix <= r_pix + 12'd1;
                    if (w_eof) begin
                        r_stop_pend <= 1'b0;
                        if (w_restart) begin
                            r_mode      <= mode_in;
                            r_x         <= x_in;
                            r_line      <= '0;
                            r_new_frame <= 1'b1;
                            r_blk       <= '0;
                            r_state     <= S_BLANK;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_eol) begin
                        r_blk   <= '0;
                        r_state <= S_BLANK;
                    end
                end
                S_BLANK: begin
                    if (stop) r_stop_pend <= 1'b1;
                    if (r_blk == BW'(H_BLANK - 1)) begin
                        // A frame-restart blank keeps line 0 for the new frame
                        if (!r_new_frame) r_line <= r_line + LW'(1);
                        r_new_frame <= 1'b0;
                        r_pix       <= 12'd0;
                        r_state     <= S_LSYNC;
                    end else begin
                        r_blk <= r_blk + BW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_timing_ctrl
// Function : Directed, table-driven bench for pattern_timing_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_pattern_timing_ctrl;

    localparam int NORM_LEN = 8;
    localparam int TEST_LEN = 4;
    localparam int LINES    = 3;
    localparam int H_BLANK  = 2;
    localparam int LW       = 2;
    localparam int NCYC     = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          cont = 1'b0;
    logic [2:0]    mode_in = 3'd0;
    logic [1:0]    x_in = 2'd0;
    logic [2:0]    mode_out;
    logic [1:0]    x_out;
    logic          f_sync, sync, endLine, endFrame, busy, cfg_err;
    logic [11:0]   pix_cnt;
    logic [LW-1:0] line_cnt;

    pattern_timing_ctrl #(
        .NORM_LEN(NORM_LEN), .TEST_LEN(TEST_LEN), .LINES(LINES), .H_BLANK(H_BLANK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cont(cont),
        .mode_in(mode_in), .x_in(x_in), .mode_out(mode_out), .x_out(x_out),
        .f_sync(f_sync), .sync(sync), .endLine(endLine), .endFrame(endFrame),
        .busy(busy), .cfg_err(cfg_err), .pix_cnt(pix_cnt), .line_cnt(line_cnt)
    );

    always #30 clk = ~clk;

    typedef struct {
        logic [2:0]  mode;
        logic [2:0]  mode_b;
        int          mode_sw;
        logic [1:0]  x;
        logic        cont;
        int          stop_cyc;
        int          start2;
        int          len;
        logic [63:0] sync_m;
        logic [63:0] fsync_m;
        logic [63:0] eol_m;
        logic [63:0] eof_m;
        logic [63:0] busy_m;
        logic [63:0] err_m;
    } vec_t;

    vec_t tbl [6];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ev(input int a, input int b = -1, input int c = -1,
                                       input int d = -1, input int e = -1, input int f = -1);
        logic [63:0] m;
        int          l [6];
        m = '0;
        l = '{a, b, c, d, e, f};
        for (int i = 0; i < 6; i++) if (l[i] >= 0) m[l[i]] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    initial begin
        tbl[0] = '{mode: 3'd3, mode_b: 3'd3, mode_sw: 99, x: 2'd1, cont: 1'b0, stop_cyc: -1, start2: 10, len: 4,
                   sync_m: ev(1, 8, 15), fsync_m: ev(1), eol_m: ev(5, 12, 19), eof_m: ev(19),
                   busy_m: rng(1, 19), err_m: '0};
        tbl[1] = '{mode: 3'd1, mode_b: 3'd1, mode_sw: 99, x: 2'd3, cont: 1'b0, stop_cyc: -1, start2: -1, len: 8,
                   sync_m: ev(1, 12, 23), fsync_m: ev(1), eol_m: ev(9, 20, 31), eof_m: ev(31),
                   busy_m: rng(1, 31), err_m: '0};
        tbl[2] = '{mode: 3'd2, mode_b: 3'd5, mode_sw: 20, x: 2'd0, cont: 1'b1, stop_cyc: -1, start2: -1, len: 4,
                   sync_m: ev(1, 8, 15, 22, 29, 36), fsync_m: ev(1, 22), eol_m: ev(5, 12, 19, 26, 33),
                   eof_m: ev(19), busy_m: rng(1, 39), err_m: '0};
        tbl[3] = '{mode: 3'd2, mode_b: 3'd2, mode_sw: 99, x: 2'd2, cont: 1'b0, stop_cyc: 3, start2: -1, len: 4,
                   sync_m: ev(1), fsync_m: ev(1), eol_m: ev(5), eof_m: ev(5),
                   busy_m: rng(1, 5), err_m: '0};
        tbl[4] = '{mode: 3'd3, mode_b: 3'd3, mode_sw: 99, x: 2'd1, cont: 1'b0, stop_cyc: 7, start2: -1, len: 4,
                   sync_m: ev(1, 8), fsync_m: ev(1), eol_m: ev(5, 12), eof_m: ev(12),
                   busy_m: rng(1, 12), err_m: '0};
        tbl[5] = '{mode: 3'd0, mode_b: 3'd0, mode_sw: 99, x: 2'd0, cont: 1'b0, stop_cyc: -1, start2: -1, len: 4,
                   sync_m: '0, fsync_m: '0, eol_m: '0, eof_m: '0, busy_m: '0, err_m: ev(1)};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_mode", mode_out, 0);
        chk("rst_pix", pix_cnt, 0);
        chk("rst_line", line_cnt, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rel_busy", busy, 0);
        chk("rel_sync", sync, 0);

        for (int s = 0; s < 6; s++) begin
            repeat (3) @(negedge clk);
            for (int cyc = 0; cyc < NCYC; cyc++) begin
                @(negedge clk);
                start   = (cyc == 0) || (cyc == tbl[s].start2);
                mode_in = (cyc >= 10) ? tbl[s].mode_b : tbl[s].mode;
                x_in    = tbl[s].x;
                cont    = tbl[s].cont;
                stop    = (cyc == tbl[s].stop_cyc);
                @(posedge clk);
                #1;
                chk($sformatf("s%0d c%0d sync", s, cyc), sync, tbl[s].sync_m[cyc]);
                chk($sformatf("s%0d c%0d f_sync", s, cyc), f_sync, tbl[s].fsync_m[cyc]);
                chk($sformatf("s%0d c%0d endLine", s, cyc), endLine, tbl[s].eol_m[cyc]);
                chk($sformatf("s%0d c%0d endFrame", s, cyc), endFrame, tbl[s].eof_m[cyc]);
                chk($sformatf("s%0d c%0d busy", s, cyc), busy, tbl[s].busy_m[cyc]);
                chk($sformatf("s%0d c%0d cfg_err", s, cyc), cfg_err, tbl[s].err_m[cyc]);
                if (cyc >= 1 && tbl[s].mode != 3'd0) begin
                    chk($sformatf("s%0d c%0d mode_out", s, cyc), mode_out,
                        (cyc < tbl[s].mode_sw) ? tbl[s].mode : tbl[s].mode_b);
                    chk($sformatf("s%0d c%0d x_out", s, cyc), x_out, tbl[s].x);
                end
                if (tbl[s].eol_m[cyc])
                    chk($sformatf("s%0d c%0d pix_eol", s, cyc), pix_cnt, tbl[s].len - 1);
                if (tbl[s].sync_m[cyc])
                    chk($sformatf("s%0d c%0d pix_sync", s, cyc), pix_cnt, 0);
            end
            @(negedge clk);
            start = 1'b0;
            stop  = 1'b0;
            cont  = 1'b0;
            begin
                int waited;
                waited = 0;
                while (busy && waited < 200) begin
                    @(negedge clk);
                    waited++;
                end
                chk($sformatf("s%0d idle_timeout", s), busy, 0);
            end
        end

        // Line counter and async reset mid-frame
        @(negedge clk);
        start   = 1'b1;
        mode_in = 3'd3;
        x_in    = 2'd2;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("line_cnt_c9", line_cnt, 1);
        chk("pix_c9", pix_cnt, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_mode", mode_out, 0);
        chk("arst_x", x_out, 0);
        chk("arst_line", line_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(posedge clk);
            #1;
            chk($sformatf("quiet c%0d", cyc), {busy, sync, f_sync, endLine, endFrame, cfg_err}, 0);
        end
        @(negedge clk);
        start   = 1'b1;
        mode_in = 3'd1;
        @(posedge clk);
        #1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("restart_fsync", f_sync, 1);
        chk("restart_mode", mode_out, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
